// File: rtl/rv_axi_pkg.sv
// Shared AXI types plus burst address helpers used by the write and read responders.
package rv_axi_pkg;

  localparam int RV_AXI_MAX_AW = 64;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_UNDEF = 2'd3
  } rv_axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } rv_axi_resp_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } rv_axi_wr_state_e;

  typedef struct packed {
    logic [RV_AXI_MAX_AW-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    rv_axi_burst_e            burst;
  } rv_axi_addr_gen_state;

  function automatic logic [RV_AXI_MAX_AW-1:0] rv_axi_next_addr(input rv_axi_addr_gen_state s);
    logic [RV_AXI_MAX_AW-1:0] nbytes, incr, wmask;
    nbytes = 64'd1 << s.size;
    incr   = (s.addr & ~(nbytes - 64'd1)) + nbytes;
    // Only power-of-two wrap lengths reach the memory; others are drained.
    wmask  = (({56'd0, s.len} + 64'd1) << s.size) - 64'd1;
    case (s.burst)
      BURST_INCR: return incr;
      BURST_WRAP: return (s.addr & ~wmask) | (incr & wmask);
      default:    return s.addr;
    endcase
  endfunction

  function automatic logic [15:0] rv_axi_lane_mask(input logic [RV_AXI_MAX_AW-1:0] addr,
                                                  input logic [2:0] size,
                                                  input int unsigned bytes);
    logic [15:0] m;
    int unsigned lo, hi;
    lo = 32'(addr[3:0]) & (bytes - 1);
    hi = ((lo >> size) + 1) << size;
    for (int unsigned i = 0; i < 16; i++)
      m[i] = (i < bytes) && (i >= lo) && (i < hi);
    return m;
  endfunction

endpackage

// File: rtl/rv_axi_intf.sv
// AXI4 write-side channel bundles (AW, W, B).
interface rv_axi_addr_write_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);
  logic                  awvalid;
  logic                  awready;
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic [USER_WIDTH-1:0] awuser;

  modport in  (input awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache,
               awprot, awqos, awuser, output awready);
  modport out (output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache,
               awprot, awqos, awuser, input awready);
endinterface

interface rv_axi_write_data_intf #(
  parameter int DATA_WIDTH = 32
);
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  modport in  (input wvalid, wdata, wstrb, wlast, output wready);
  modport out (output wvalid, wdata, wstrb, wlast, input wready);
endinterface

interface rv_axi_write_resp_intf #(
  parameter int ID_WIDTH = 1
);
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;

  modport out (output bvalid, bid, bresp, input bready);
  modport in  (input bvalid, bid, bresp, output bready);
endinterface

// File: rtl/rv_axi_burst_addr_gen.sv
// Registered burst address; loads on AW acceptance and steps once per completed beat.
module rv_axi_burst_addr_gen
  import rv_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  rv_axi_addr_gen_state load_state,
  input  logic                 advance,
  output rv_axi_addr_gen_state state
);

  // Keeps every address ADDR_WIDTH-bit modulo even though the shared struct is wider.
  localparam logic [RV_AXI_MAX_AW-1:0] AMASK = (64'd1 << ADDR_WIDTH) - 64'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state      <= load_state;
      state.addr <= load_state.addr & AMASK;
    end else if (advance) begin
      state.addr <= rv_axi_next_addr(state) & AMASK;
    end
  end

endmodule

// File: rtl/rv_axi_write_responder.sv
// AXI4 write responder: one burst at a time, split into byte-strobed single-beat memory writes.
module rv_axi_write_responder
  import rv_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rv_axi_addr_write_intf.in       aw,
  rv_axi_write_data_intf.in       w,
  rv_axi_write_resp_intf.out      b,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data,
  output logic [DATA_WIDTH/8-1:0] mem_strb
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(BYTES));
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  rv_axi_wr_state_e     st;
  logic                 awready_q, bvalid_q, drain, decerr, slverr;
  rv_axi_resp_e         bresp_q;
  logic [ID_WIDTH-1:0]  id_q, bid_q;
  logic [7:0]           beat_cnt;
  rv_axi_addr_gen_state load_st, cur;
  logic                 aw_hs, beat_done, last_beat, wlast_err;
  logic                 aw_decerr, aw_slverr;
  logic [65:0]          start, nb, span, first, last;

  // AW legality, evaluated on the live channel so the verdict is latched with the burst.
  always_comb begin
    start = 66'(aw.awaddr);
    nb    = 66'd1 << aw.awsize;
    span  = (66'(aw.awlen) + 66'd1) << aw.awsize;
    case (aw.awburst)
      BURST_FIXED: begin first = start & ~(nb - 66'd1);   last = first + nb - 66'd1;   end
      BURST_WRAP:  begin first = start & ~(span - 66'd1); last = first + span - 66'd1; end
      default:     begin first = start & ~(nb - 66'd1);   last = first + span - 66'd1; end
    endcase
    aw_decerr = (start >= 66'(MEM_BYTES)) || (last >= 66'(MEM_BYTES));
    aw_slverr = (aw.awsize > MAX_SIZE) || (aw.awburst == BURST_UNDEF) ||
                ((aw.awburst == BURST_WRAP) && !(aw.awlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                ((aw.awburst == BURST_WRAP) && ((start & (nb - 66'd1)) != 66'd0));
  end

  assign aw_hs     = (st == WR_IDLE) && aw.awvalid;
  assign w.wready  = (st == WR_DATA) && (drain || mem_ready);
  assign mem_valid = (st == WR_DATA) && !drain && w.wvalid;
  assign beat_done = (st == WR_DATA) && w.wvalid && w.wready;
  assign last_beat = (beat_cnt == cur.len);
  assign wlast_err = (w.wlast != last_beat);

  assign load_st.addr  = RV_AXI_MAX_AW'(aw.awaddr);
  assign load_st.len   = aw.awlen;
  assign load_st.size  = aw.awsize;
  assign load_st.burst = rv_axi_burst_e'(aw.awburst);

  rv_axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (aw_hs),
    .load_state (load_st),
    .advance    (beat_done),
    .state      (cur)
  );

  assign mem_addr = cur.addr[ADDR_WIDTH-1:0] & ALIGN_MASK;
  assign mem_data = w.wdata;
  assign mem_strb = w.wstrb & BYTES'(rv_axi_lane_mask(cur.addr, cur.size, 32'(BYTES)));

  assign aw.awready = awready_q;
  assign b.bvalid   = bvalid_q;
  assign b.bresp    = bresp_q;
  assign b.bid      = bid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= WR_IDLE;
      awready_q <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      id_q      <= '0;
      drain     <= 1'b0;
      decerr    <= 1'b0;
      slverr    <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      case (st)
        WR_IDLE: if (aw.awvalid) begin
          id_q      <= aw.awid;
          beat_cnt  <= '0;
          decerr    <= aw_decerr;
          slverr    <= aw_slverr;
          drain     <= aw_decerr || aw_slverr;
          awready_q <= 1'b0;
          st        <= WR_DATA;
        end
        WR_DATA: if (beat_done) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (wlast_err) slverr <= 1'b1;
          // Beat count follows AWLEN; a misplaced WLAST only flags the response.
          if (last_beat) begin
            st       <= WR_RESP;
            bvalid_q <= 1'b1;
            bid_q    <= id_q;
            bresp_q  <= decerr ? RESP_DECERR :
                        (slverr || wlast_err) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        WR_RESP: if (b.bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          st        <= WR_IDLE;
        end
        default: st <= WR_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{aw.awlock, aw.awcache, aw.awprot, aw.awqos, aw.awuser, cur.addr, cur.burst};

endmodule

// File: doc/rv_axi_write_responder.md
Name: rv_axi_write_responder

Overview:
AXI4 write-side responder (subordinate). Terminates the AW, W and B channels and converts each accepted burst into a sequence of single-beat byte-strobed writes on a simple valid/ready memory port. It sits in front of on-chip RAM or register banks that are driven by AXI write initiators elsewhere in the design. One transaction is outstanding at a time.

Parameters:
ADDR_WIDTH, 32, AW address width and mem_addr width.
DATA_WIDTH, 32, W data width; 32, 64 or 128 only.
ID_WIDTH, 1, AWID/BID width.
USER_WIDTH, 1, AWUSER width; AWUSER is ignored.
MEM_BYTES, 4096, decoded region size in bytes, starting at address 0.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
aw  rv_axi_addr_write_intf.in  -  AW channel (AWVALID/AWREADY plus fields).
w  rv_axi_write_data_intf.in  -  W channel.
b  rv_axi_write_resp_intf.out  -  B channel.
mem_valid  out  1  memory write request.
mem_ready  in  1  memory accepts request.
mem_addr  out  ADDR_WIDTH  beat byte address, aligned down to the DATA_WIDTH/8 boundary.
mem_data  out  DATA_WIDTH  = WDATA.
mem_strb  out  DATA_WIDTH/8  = WSTRB masked to the beat's active lanes.

Behaviour:
- Reset (async assert, sync deassert at the source): state=IDLE. AWREADY=1, WREADY=0, BVALID=0, BRESP=OKAY, BID=0, mem_valid=0. Reset mid-burst aborts the burst. No B response is sent for an aborted burst.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - AWREADY=1 and WREADY=0. W beats that arrive early are held off.
  - On AWVALID, latch addr, len, size, burst and id. Clear beat_cnt and the error flags. Go to DATA.
- AW checks at acceptance:
  - DECERR if start addr >= MEM_BYTES, or if the burst's last byte is >= MEM_BYTES (use the wrap window for WRAP).
  - SLVERR if any of these holds: AWSIZE > log2(DATA_WIDTH/8); AWBURST==UNDEF; WRAP with len+1 not in {2,4,8,16}; WRAP with start addr not size-aligned.
  - DECERR takes priority over SLVERR. Any AW error puts the burst in drain mode.
- DATA:
  - WREADY = drain ? 1 : mem_ready.
  - mem_valid = !drain && WVALID. This is a combinational path; there is no skid buffer.
  - A beat completes on WVALID && WREADY. On completion: beat_cnt++ and advance the address.
  - On the beat where beat_cnt==len, go to RESP.
  - If WLAST != (beat_cnt==len) on any beat, set SLVERR. The write still occurs, and the beat count stays governed by AWLEN.
- Address advance:
  - FIXED: address unchanged.
  - INCR: addr = (addr aligned down to 2^size) + 2^size.
  - WRAP: same as INCR, but wraps inside a window of (len+1)*2^size bytes aligned to that size.
  - All arithmetic is ADDR_WIDTH-bit modulo.
- Lane mask: bytes [addr mod (DATA_WIDTH/8)] up to the next 2^size boundary. mem_strb = WSTRB & mask.
- RESP:
  - BVALID=1, BID = latched id, BRESP = DECERR, else SLVERR, else OKAY.
  - Stay in RESP until BREADY. On BREADY, go to IDLE (AWREADY is 1 the next cycle).
  - BVALID is held stable with stable fields until accepted.
- Throughput: 1 beat/cycle while mem_ready=1. Minimum burst cost is 1 (AW) + len+1 (W) + 1 (B) cycles.
- AWLOCK, AWCACHE, AWPROT, AWQOS and AWUSER are ignored. EXOKAY is never returned.

Decomposition:
- Add to the shared rv_axi package:
  - an rv_axi_addr_gen_state struct (addr, len, size, burst);
  - a function rv_axi_next_addr(state) implementing FIXED/INCR/WRAP;
  - a function rv_axi_lane_mask(addr, size, bytes).
- One sub-module, rv_axi_burst_addr_gen. It holds the registered burst address and advances it on beat completion. The matching read responder will reuse it.

Test Plan:
- Single INCR beat: AW addr=0x10, len=0, size=2, id=1; W data=0xDEADBEEF, strb=0xF, last=1; mem_ready=1 -> one mem write at 0x10 with strb 0xF, then BRESP=OKAY, BID=1.
- INCR burst with backpressure: addr=0x100, len=3, size=2; mem_ready toggles 1,0,1,... -> mem_addr 0x100, 0x104, 0x108, 0x10C in order. WREADY tracks mem_ready, one B response after the 4th beat.
- WRAP burst: addr=0x38, len=3, size=2 (16-byte window 0x30) -> mem_addr 0x38, 0x3C, 0x30, 0x34, BRESP=OKAY. Narrow write on 32-bit data, size=0, addr=0x3, strb=0xF -> mem_strb=0x8.
- Errors: AW addr=MEM_BYTES -> no mem_valid, all len+1 beats drained, BRESP=DECERR. AWBURST=UNDEF -> BRESP=SLVERR. WLAST asserted on beat 1 of len=3 -> all 4 writes occur, BRESP=SLVERR.
- Handshake ordering and reset: W presented before AW -> WREADY=0 until AW is accepted. BREADY held low for 5 cycles -> BVALID/BRESP/BID stable and AWREADY=0. rst_n asserted mid-burst -> outputs return to reset values immediately and no B response is issued.
